// File: rtl/als_pkg.sv
// Shared constants and frame-field helpers for the PmodALS light-level path.
// Frame layout: 3 leading zeros, 8 data bits, 4 trailing zeros, 1 don't-care bit.
package als_pkg;

    localparam int ALS_FRAME_W   = 16;
    localparam int ALS_DATA_W    = 8;
    localparam int ALS_LEAD_MSB  = 15;
    localparam int ALS_LEAD_LSB  = 13;
    localparam int ALS_DATA_MSB  = 12;
    localparam int ALS_DATA_LSB  = 5;
    localparam int ALS_TRAIL_MSB = 4;
    localparam int ALS_TRAIL_LSB = 1;
    localparam int ALS_BAR_STEP  = 16;
    localparam int ALS_BAR_W     = 4;

    typedef enum logic [1:0] {
        BAR_HOLD = 2'b00,
        BAR_UP   = 2'b01,
        BAR_DOWN = 2'b10
    } bar_step_e;

    function automatic logic als_frame_good(input logic [ALS_FRAME_W-1:0] frame);
        als_frame_good = (frame[ALS_LEAD_MSB:ALS_LEAD_LSB] == 3'b000) &&
                         (frame[ALS_TRAIL_MSB:ALS_TRAIL_LSB] == 4'b0000);
    endfunction

    function automatic logic [ALS_DATA_W-1:0] als_frame_sample(input logic [ALS_FRAME_W-1:0] frame);
        als_frame_sample = frame[ALS_DATA_MSB:ALS_DATA_LSB];
    endfunction

endpackage

// File: rtl/als_bar_encoder.sv
// Combinational 4-bit level to 16-bit thermometer code: bit i lit when i < level.
module als_bar_encoder
    import als_pkg::*;
(
    input  logic [ALS_BAR_W-1:0]   level,
    output logic [ALS_FRAME_W-1:0] therm
);

    // Thermometer expansion of the level
    always_comb begin
        therm = '0;
        for (int i = 0; i < ALS_FRAME_W; i++) begin
            therm[i] = (5'(i) < {1'b0, level});
        end
    end

endmodule

// File: rtl/als_level_filter.sv
// Frame check, block averaging, hysteretic bar-graph LED drive and stale-input
// detection for captured ADC081S021 frames.
module als_level_filter
    import als_pkg::*;
#(
    parameter int AVG_LOG2     = 2,
    parameter int HYST         = 4,
    parameter int STALE_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ALS_FRAME_W-1:0] frame_in,
    input  logic                   frame_valid,
    input  logic                   mode,
    output logic [ALS_FRAME_W-1:0] led,
    output logic [ALS_DATA_W-1:0]  avg_out,
    output logic                   avg_valid,
    output logic                   frame_err,
    output logic                   stale
);

    localparam int ACC_W = ALS_DATA_W + AVG_LOG2;
    localparam int TMR_W = $clog2(STALE_CYCLES);
    localparam logic [AVG_LOG2-1:0] CNT_LAST   = {AVG_LOG2{1'b1}};
    localparam logic [TMR_W-1:0]    TMR_RELOAD = TMR_W'(STALE_CYCLES - 1);

    logic [ACC_W-1:0]       acc_q, acc_d, acc_sum_s;
    logic [AVG_LOG2-1:0]    cnt_q, cnt_d;
    logic [ALS_DATA_W-1:0]  avg_q, avg_d, sample_s;
    logic                   avg_valid_q, avg_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   stale_q, stale_d;
    logic [ALS_BAR_W-1:0]   bar_q, bar_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [ALS_FRAME_W-1:0] led_q, led_d, therm_s;
    logic                   good_s, expire_s;
    logic [9:0]             avg_ext_s, up_thr_s, down_thr_s;
    bar_step_e              step_s;

    assign good_s    = als_frame_good(frame_in);
    assign sample_s  = als_frame_sample(frame_in);
    assign acc_sum_s = acc_q + {{AVG_LOG2{1'b0}}, sample_s};
    // The timer sits at zero once expired, so expiry re-fires every idle cycle while stale.
    assign expire_s  = !frame_valid && (tmr_q == {TMR_W{1'b0}});

    // Frame acceptance, accumulation, block completion and stale timer
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        frame_err_d = 1'b0;
        stale_d     = stale_q;
        tmr_d       = tmr_q;
        if (frame_valid) begin
            tmr_d   = TMR_RELOAD;
            stale_d = 1'b0;
            if (good_s) begin
                if (cnt_q == CNT_LAST) begin
                    avg_d       = acc_sum_s[ACC_W-1:AVG_LOG2];
                    avg_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = acc_sum_s;
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end else if (expire_s) begin
            stale_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            tmr_d = tmr_q - 1'b1;
        end
    end

    // Up/down decision for the bar level against the latest average
    always_comb begin
        avg_ext_s  = {2'b00, avg_q};
        up_thr_s   = ({6'd0, bar_q} + 10'd1) * 10'(ALS_BAR_STEP);
        down_thr_s = {6'd0, bar_q} * 10'(ALS_BAR_STEP);
        if ((bar_q != 4'd15) && (avg_ext_s >= up_thr_s)) begin
            step_s = BAR_UP;
        end else if ((bar_q != 4'd0) && ((avg_ext_s + 10'(HYST)) < down_thr_s)) begin
            step_s = BAR_DOWN;
        end else begin
            step_s = BAR_HOLD;
        end
    end

    // Bar level: one step per average, cleared when input goes stale
    always_comb begin
        bar_d = bar_q;
        if (expire_s) begin
            bar_d = '0;
        end else if (avg_valid_q) begin
            case (step_s)
                BAR_UP:   bar_d = bar_q + 1'b1;
                BAR_DOWN: bar_d = bar_q - 1'b1;
                default:  bar_d = bar_q;
            endcase
        end else begin
            bar_d = bar_q;
        end
    end

    als_bar_encoder u_bar_encoder (
        .level (bar_d),
        .therm (therm_s)
    );

    // LED source select from next-state values so led tracks the same edge
    always_comb begin
        if (stale_d) begin
            led_d = '0;
        end else if (mode) begin
            led_d = {8'h00, avg_d};
        end else begin
            led_d = therm_s;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            stale_q     <= 1'b0;
            bar_q       <= '0;
            tmr_q       <= TMR_RELOAD;
            led_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            frame_err_q <= frame_err_d;
            stale_q     <= stale_d;
            bar_q       <= bar_d;
            tmr_q       <= tmr_d;
            led_q       <= led_d;
        end
    end

    assign led       = led_q;
    assign avg_out   = avg_q;
    assign avg_valid = avg_valid_q;
    assign frame_err = frame_err_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_als_level_filter.sv
// Self-checking bench for als_level_filter: directed scenarios plus randomized
// traffic checked every cycle against a queue-based behavioural model.
module tb_als_level_filter;

    localparam int AVG_LOG2 = 2;
    localparam int N        = 4;
    localparam int HYST     = 4;
    localparam int S        = 8;

    logic        clk;
    logic        rst;
    logic [15:0] frame_in;
    logic        frame_valid;
    logic        mode;
    logic [15:0] led;
    logic [7:0]  avg_out;
    logic        avg_valid;
    logic        frame_err;
    logic        stale;

    int n_tests = 0;
    int n_fail  = 0;

    als_level_filter #(
        .AVG_LOG2     (AVG_LOG2),
        .HYST         (HYST),
        .STALE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .mode        (mode),
        .led         (led),
        .avg_out     (avg_out),
        .avg_valid   (avg_valid),
        .frame_err   (frame_err),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: current block kept as a list of samples
    int   m_blk[$];
    int   m_bar, m_avg, m_idle, m_sum, m_pend, m_pavg;
    bit   m_avgv, m_err, m_stale, m_live, m_exp;
    logic [15:0] m_led;

    initial m_live = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_blk.delete();
            m_bar = 0; m_avg = 0; m_idle = 0;
            m_avgv = 0; m_err = 0; m_stale = 0;
            m_led = 16'h0000;
            m_live = 1'b1;
        end else begin
            m_pend = m_avgv;
            m_pavg = m_avg;
            m_avgv = 0; m_err = 0; m_exp = 0;
            if (frame_valid) begin
                m_idle  = 0;
                m_stale = 0;
                if (frame_in[15:13] == 3'd0 && frame_in[4:1] == 4'd0) begin
                    m_blk.push_back(int'(frame_in[12:5]));
                    if (m_blk.size() == N) begin
                        m_sum = 0;
                        foreach (m_blk[k]) m_sum += m_blk[k];
                        m_avg  = m_sum / N;
                        m_avgv = 1;
                        m_blk.delete();
                    end
                end else begin
                    m_err = 1;
                end
            end else begin
                if (m_idle < S) m_idle++;
                if (m_idle >= S) begin
                    m_exp = 1; m_stale = 1; m_bar = 0;
                    m_blk.delete();
                end
            end
            if (m_pend && !m_exp) begin
                if (m_bar < 15 && m_pavg >= (m_bar + 1) * 16) m_bar++;
                else if (m_bar >= 1 && m_pavg + HYST < m_bar * 16) m_bar--;
            end
            if (m_stale)   m_led = 16'h0000;
            else if (mode) m_led = {8'h00, 8'(m_avg)};
            else           m_led = 16'((32'd1 << m_bar) - 32'd1);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("led",       32'(led),       32'(m_led));
            chk("avg_out",   32'(avg_out),   32'(m_avg));
            chk("avg_valid", 32'(avg_valid), 32'(m_avgv));
            chk("frame_err", 32'(frame_err), 32'(m_err));
            chk("stale",     32'(stale),     32'(m_stale));
        end
    end

    task automatic send(input logic [15:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic send_block(input logic [15:0] f);
        for (int k = 0; k < N; k++) send(f);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] rand_frame();
        logic [15:0] f;
        if ($urandom_range(0, 9) < 8) f = {3'b000, 8'($urandom_range(0, 255)), 4'b0000, 1'($urandom_range(0, 1))};
        else                          f = 16'($urandom());
        return f;
    endfunction

    int r;

    initial begin
        rst = 1'b0; frame_valid = 1'b0; frame_in = 16'h0000; mode = 1'b0;
        idle(2);
        chk("rst_led",   32'(led),     32'h0000);
        chk("rst_avg",   32'(avg_out), 32'h00);
        chk("rst_stale", 32'(stale),   32'h0);
        rst = 1'b1;

        // Eight blocks of 0x80 walk the bar up to level 8
        for (int b = 0; b < 8; b++) begin
            send_block(16'h1000);
            chk("blk80_valid", 32'(avg_valid), 32'h1);
            chk("blk80_avg",   32'(avg_out),   32'h80);
        end
        idle(1);
        chk("bar8_led", 32'(led), 32'h00FF);

        // Hysteresis: 126 holds level 8, 123 drops to 7
        send_block(16'h0FC0);
        chk("avg126", 32'(avg_out), 32'd126);
        idle(1);
        chk("hold8_led", 32'(led), 32'h00FF);
        send_block(16'h0F60);
        chk("avg123", 32'(avg_out), 32'd123);
        idle(1);
        chk("down7_led", 32'(led), 32'h007F);

        // Framing errors mixed with good frames; bit 0 ignored
        send(16'h1000);
        send(16'h3000);
        chk("err_lead", 32'(frame_err), 32'h1);
        send(16'h1000);
        send(16'h1002);
        chk("err_trail", 32'(frame_err), 32'h1);
        send(16'h1001);
        chk("bit0_ok", 32'(frame_err), 32'h0);
        send(16'h0800);
        chk("mix_valid", 32'(avg_valid), 32'h1);
        chk("mix_avg",   32'(avg_out),   32'h70);

        // Mode switching
        mode = 1'b1; idle(1);
        chk("mode1_led", 32'(led), 32'h0070);
        mode = 1'b0; idle(1);
        chk("mode0_led", 32'(led), 32'h007F);
        send_block(16'h1FE0);
        chk("avgFF", 32'(avg_out), 32'hFF);
        mode = 1'b1; idle(1);
        chk("rawFF_led", 32'(led), 32'h00FF);
        mode = 1'b0; idle(1);
        chk("bar8b_led", 32'(led), 32'h00FF);

        // Stale after S idle cycles, partial block discarded
        send(16'h1000);
        send(16'h1000);
        idle(S - 1);
        chk("not_stale_yet", 32'(stale), 32'h0);
        idle(1);
        chk("stale_set",  32'(stale),   32'h1);
        chk("stale_led",  32'(led),     32'h0000);
        chk("stale_avg",  32'(avg_out), 32'hFF);
        send(16'h0200);
        chk("stale_clr", 32'(stale), 32'h0);
        send(16'h0200); send(16'h0200); send(16'h0200);
        chk("post_stale_avg", 32'(avg_out), 32'h10);
        idle(S - 1);
        send(16'h0200);
        chk("expiry_frame", 32'(stale), 32'h0);
        send(16'h0200); send(16'h0200); send(16'h0200);

        // Reset mid-block
        send(16'h1FE0); send(16'h1FE0); send(16'h1FE0);
        rst = 1'b0; idle(1); rst = 1'b1;
        chk("mrst_avg", 32'(avg_out), 32'h00);
        chk("mrst_led", 32'(led),     32'h0000);
        send_block(16'h0200);
        chk("mrst_blk", 32'(avg_out), 32'h10);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                frame_valid = 1'b0; rst = 1'b0;
                idle(1);
                rst = 1'b1;
            end else if (r < 6) begin
                frame_valid = 1'b0;
                idle(int'($urandom_range(S - 2, S + 4)));
            end else begin
                if ($urandom_range(0, 29) == 0) mode = ~mode;
                if ($urandom_range(0, 9) < 7) begin
                    frame_in = rand_frame();
                    frame_valid = 1'b1;
                end else begin
                    frame_valid = 1'b0;
                end
                idle(1);
            end
        end
        frame_valid = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/als_level_filter.md
Name: als_level_filter

Overview:
- Downstream stage of the PmodALS SPI reader. It consumes each captured 16-bit ADC081S021 frame and checks the framing bits.
- It extracts the 8-bit light sample and averages non-overlapping blocks of 2^AVG_LOG2 samples.
- It drives the 16 board LEDs as a slewed, hysteretic bar graph, or as the raw average. It also flags bad or stale input.

Parameters:
AVG_LOG2, 2, log2 of samples per average (1..6)
HYST, 4, downward hysteresis in LSBs of the 8-bit average
STALE_CYCLES, 1000000, clk cycles without a valid frame before stale is declared (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
frame_in  in  16  captured SPI frame, first-shifted bit in [15]
frame_valid  in  1  one-cycle strobe; frame_in is valid in that cycle
mode  in  1  0 = bar graph on led, 1 = raw average on led
led  out  16  LED drive
avg_out  out  8  latest block average
avg_valid  out  1  one-cycle pulse when avg_out updates
frame_err  out  1  one-cycle pulse when a frame is rejected
stale  out  1  high while input is stale

Behaviour:
- Reset (rst==0 at posedge): led=0, avg_out=0, avg_valid=0, frame_err=0, stale=0. Accumulator, sample count, bar_level and the stale timer are cleared. A reset mid-block discards the partial block.
- Frame check on frame_valid: the frame is good iff frame_in[15:13]==0 and frame_in[4:1]==0. frame_in[0] is ignored.
- Sample extraction: sample = frame_in[12:5].
- Bad frame: frame_err pulses one cycle later. The sample is dropped. The accumulator and count are unchanged. The stale timer still reloads.
- Accumulate: acc is 8+AVG_LOG2 bits wide and cannot overflow. Each good frame does acc+=sample and cnt+=1.
- Block completion: on the good frame where cnt==2^AVG_LOG2-1, the following happen on the next edge.
  - avg_out = (acc+sample)>>AVG_LOG2, truncating.
  - avg_valid pulses for that one cycle.
  - acc and cnt are cleared.
- Latency: the last frame_valid of a block is followed by avg_valid exactly one cycle later.
- Bar FSM: bar_level is 0..15. It updates in the cycle after avg_valid, with at most one step per average.
  - Up: avg_out >= (bar_level+1)*16, only when bar_level<15.
  - Down: bar_level>=1 and avg_out + HYST < bar_level*16.
  - Otherwise bar_level holds.
- led when mode=0: thermometer code, led[i]=1 for i<bar_level.
- led when mode=1: {8'h00, avg_out}.
- led is registered and follows a mode change within one cycle.
- Stale timer:
  - It reloads on every frame_valid and otherwise counts down.
  - On reaching 0: stale=1, led=0, and acc, cnt and bar_level are cleared. avg_out holds its value.
  - The first frame_valid afterwards clears stale on the next edge. That frame is then processed normally.
- Simultaneous events: frame_valid in the same cycle as timer expiry counts as a frame, so stale is not asserted.
- frame_valid held high on consecutive cycles is legal; each cycle is one frame.

Decomposition:
- Shared package als_pkg:
  - ALS_FRAME_W=16, ALS_DATA_W=8.
  - Field constants ALS_LEAD_MSB=15, ALS_LEAD_LSB=13, ALS_DATA_MSB=12, ALS_DATA_LSB=5, ALS_TRAIL_MSB=4, ALS_TRAIL_LSB=1.
  - Bar step size ALS_BAR_STEP=16.
- One sub-module, als_bar_encoder: combinational 4-bit level to 16-bit thermometer code, instantiated once for the mode=0 LED path.

Test Plan:
- Reset with mode=0, then 4 frames of 0x1000 (sample 0x80), then repeat that 4-frame block 7 more times → each block gives avg_out=0x80 and avg_valid one cycle after its 4th strobe. bar_level steps 1,2,…,8 over the 8 averages; led=0x00FF at the end.
- From level 8, a block of samples 0x7E (frames 0x0FC0) → avg 126, level holds 8 (126+4 ≥ 128). A block of 0x7B (frames 0x0F60) → avg 123, level becomes 7, led=0x007F.
- Frames 0x3000, 0x1002, 0x1001 mixed between good frames → the first two pulse frame_err and are not counted. 0x1001 is accepted (bit 0 ignored). The average of samples {0x80,0x80,0x80,0x40} is 0x70.
- mode=1 after average 0xFF (four frames 0x1FE0) → led=0x00FF next cycle. Toggling to mode=0 shows the thermometer code.
- STALE_CYCLES=8, no frames → stale=1 and led=0 after 8 cycles. A frame in the expiry cycle prevents stale. A partial block of 2 frames before going stale is discarded.
- Reset asserted after 3 of 4 frames → everything clears. The next 4 frames 0x0200 (sample 0x10) give avg 0x10 with no residue from before reset.
